// File: rtl/ecd_pp_sched.sv
// Ping-pong buffer job scheduler: gates the producer into one of two buffers,
// drains FULL buffers to the consumer, and sequences start/busy/done/abort.
module ecd_pp_sched #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned JOB_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [JOB_W-1:0]      job_num,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic                  buf_wen,
  output logic                  buf_wsel,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  input  logic                  out_rdy,
  output logic                  buf_rd,
  output logic                  buf_rsel,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  output logic                  out_vld,
  output logic [1:0]            buf_full
);

  localparam int unsigned DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);
  localparam logic [JOB_W-1:0]      J_ONE     = JOB_W'(1);
  localparam logic [DW-1:0]         D_ONE     = DW'(1);
  localparam logic [DW-1:0]         D_LAST    = DW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wcnt, rcnt;
  logic [JOB_W-1:0]        wr_left, rd_left;
  logic                    wsel, rsel;
  logic [DW-1:0]           drain_cnt;
  logic [RD_LATENCY-1:0]   vld_pipe;

  logic                    wr_go, rd_go, w_wrap, r_wrap, abort_go;
  logic [1:0]              full_nxt;

  // Producer may push only while running into a non-FULL buffer with frames left.
  assign in_rdy  = (state == S_RUN) & ~buf_full[wsel] & (wr_left != '0);
  assign out_vld = vld_pipe[RD_LATENCY-1];

  // Handshake, frame-wrap and FULL-flag next-state decode.
  always_comb begin
    wr_go    = in_vld & in_rdy;
    rd_go    = (state == S_RUN) & buf_full[rsel] & out_rdy & (rd_left != '0);
    w_wrap   = wr_go & (wcnt == LAST_ADDR);
    r_wrap   = rd_go & (rcnt == LAST_ADDR);
    abort_go = abort & (state != S_IDLE);
    full_nxt = buf_full;
    // w_wrap needs ~full[wsel] and r_wrap needs full[rsel], so they never hit the same bit.
    if (w_wrap) full_nxt[wsel] = 1'b1;
    if (r_wrap) full_nxt[rsel] = 1'b0;
  end

  // Job FSM together with write/read counters and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_wen   <= 1'b0;
      buf_wsel  <= 1'b0;
      buf_waddr <= '0;
      buf_rd    <= 1'b0;
      buf_rsel  <= 1'b0;
      buf_raddr <= '0;
      buf_full  <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      wr_left   <= '0;
      rd_left   <= '0;
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      drain_cnt <= '0;
    end else if (abort_go) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_wen   <= 1'b0;
      buf_rd    <= 1'b0;
      buf_full  <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      wr_left   <= '0;
      rd_left   <= '0;
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      buf_wen  <= wr_go;
      buf_rd   <= rd_go;
      buf_full <= full_nxt;
      done     <= 1'b0;

      if (wr_go) begin
        buf_wsel  <= wsel;
        buf_waddr <= wcnt;
        wcnt      <= wcnt + A_ONE;
        if (w_wrap) begin
          wsel    <= ~wsel;
          wr_left <= wr_left - J_ONE;
        end
      end

      if (rd_go) begin
        buf_rsel  <= rsel;
        buf_raddr <= rcnt;
        rcnt      <= rcnt + A_ONE;
        if (r_wrap) begin
          rsel    <= ~rsel;
          rd_left <= rd_left - J_ONE;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (job_num == '0) begin
              state <= S_DONE;
            end else begin
              wr_left <= job_num;
              rd_left <= job_num;
              wcnt    <= '0;
              rcnt    <= '0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_wrap && (rd_left == J_ONE)) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + D_ONE;
          if (drain_cnt == D_LAST) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-valid pipe: out_vld is buf_rd delayed by the buffer read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (abort_go) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= buf_rd;
      for (int unsigned i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_ecd_pp_sched.sv
// Bench for ecd_pp_sched: frame-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ecd_pp_sched;
  localparam int D    = 8;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (RD_LATENCY=1)
  logic       start = 0, abort = 0, in_vld = 0, out_rdy = 0;
  logic [7:0] job_num = '0;
  logic       busy, done, in_rdy, buf_wen, buf_wsel, buf_rd, buf_rsel, out_vld;
  logic [2:0] buf_waddr, buf_raddr;
  logic [1:0] buf_full;

  // second DUT (RD_LATENCY=3)
  logic       t_start = 0, t_abort = 0, t_vld = 0, t_rdy = 0;
  logic [7:0] t_job = '0;
  logic       t_busy, t_done, t_in_rdy, t_wen, t_wsel, t_rd, t_rsel, t_out_vld;
  logic [2:0] t_waddr, t_raddr;
  logic [1:0] t_full;

  ecd_pp_sched #(.DEPTH(8), .ADDR_WIDTH(3), .RD_LATENCY(LAT), .JOB_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .job_num(job_num),
    .busy(busy), .done(done), .in_vld(in_vld), .in_rdy(in_rdy),
    .buf_wen(buf_wen), .buf_wsel(buf_wsel), .buf_waddr(buf_waddr),
    .out_rdy(out_rdy), .buf_rd(buf_rd), .buf_rsel(buf_rsel), .buf_raddr(buf_raddr),
    .out_vld(out_vld), .buf_full(buf_full));

  ecd_pp_sched #(.DEPTH(8), .ADDR_WIDTH(3), .RD_LATENCY(LAT3), .JOB_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(t_start), .abort(t_abort), .job_num(t_job),
    .busy(t_busy), .done(t_done), .in_vld(t_vld), .in_rdy(t_in_rdy),
    .buf_wen(t_wen), .buf_wsel(t_wsel), .buf_waddr(t_waddr),
    .out_rdy(t_rdy), .buf_rd(t_rd), .buf_rsel(t_rsel), .buf_raddr(t_raddr),
    .out_vld(t_out_vld), .buf_full(t_full));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (frame/word totals) ----------------
  // phase: 0 idle, 1 run, 2 drain, 3 done
  int m_phase, m_n, m_wtot, m_rtot, m_jbase, m_dcnt;
  bit e_wen, e_wsel, e_rd, e_rsel, e_done, e_vld, e_busy;
  int e_waddr, e_raddr;
  bit vq[$];

  function automatic logic [1:0] m_full();
    logic [1:0] f = '0;
    for (int k = m_rtot / D; k < m_wtot / D; k++) f[(m_jbase + k) % 2] = 1'b1;
    return f;
  endfunction

  function automatic bit m_inrdy();
    return (m_phase == 1) && ((m_wtot / D - m_rtot / D) < 2) && (m_wtot / D < m_n);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_wtot = 0; m_rtot = 0; m_jbase = 0; m_dcnt = 0;
    e_wen = 0; e_wsel = 0; e_rd = 0; e_rsel = 0; e_done = 0; e_vld = 0; e_busy = 0;
    e_waddr = 0; e_raddr = 0;
    vq.delete();
    for (int i = 0; i < LAT - 1; i++) vq.push_back(1'b0);
  endtask

  task automatic model_advance();
    int fw, fr;
    bit hs, rd;
    fw = m_wtot / D;
    fr = m_rtot / D;
    hs = m_inrdy() && in_vld;
    rd = (m_phase == 1) && out_rdy && (fw > fr);
    if (abort && m_phase != 0) begin
      m_phase = 0; m_n = 0; m_wtot = 0; m_rtot = 0; m_jbase = 0; m_dcnt = 0;
      e_wen = 0; e_rd = 0; e_done = 0; e_busy = 0; e_vld = 0;
      vq.delete();
      for (int i = 0; i < LAT - 1; i++) vq.push_back(1'b0);
      return;
    end
    vq.push_back(e_rd);
    e_vld = vq.pop_front();
    e_wen = hs;
    if (hs) begin
      e_wsel = 1'((m_jbase + fw) % 2);
      e_waddr = m_wtot % D;
      m_wtot++;
    end
    e_rd = rd;
    if (rd) begin
      e_rsel = 1'((m_jbase + fr) % 2);
      e_raddr = m_rtot % D;
      m_rtot++;
    end
    e_done = (m_phase == 3);
    case (m_phase)
      0: if (start && !abort) begin
           if (job_num == 0) m_phase = 3;
           else begin
             m_jbase = (m_jbase + m_wtot / D) % 2;
             m_n = int'(job_num); m_wtot = 0; m_rtot = 0; m_phase = 1;
           end
         end
      1: if (rd && m_rtot == m_n * D) begin m_phase = 2; m_dcnt = 0; end
      2: begin m_dcnt++; if (m_dcnt == LAT) m_phase = 3; end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_advance();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1; start = 0; abort = 0; in_vld = 0; out_rdy = 0; job_num = '0;
    t_start = 0; t_vld = 0; t_rdy = 0; t_job = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("in_rdy", in_rdy, m_inrdy());
      chk("buf_wen", buf_wen, e_wen);
      chk("buf_wsel", buf_wsel, e_wsel);
      chk("buf_waddr", buf_waddr, e_waddr);
      chk("buf_rd", buf_rd, e_rd);
      chk("buf_rsel", buf_rsel, e_rsel);
      chk("buf_raddr", buf_raddr, e_raddr);
      chk("out_vld", out_vld, e_vld);
      chk("buf_full", buf_full, m_full());
    end
  end

  int nw, nr, nd, nv, done_t, first_rd, last_rd, first_vld, last_vld;
  bit seen, ovl;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    // reset state
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_wen", buf_wen, 0);     chk("rst_rd", buf_rd, 0);
    chk("rst_vld", out_vld, 0);     chk("rst_full", buf_full, 0);
    chk("rst_waddr", buf_waddr, 0); chk("rst_raddr", buf_raddr, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk_on = 1;

    // ---- single job ----
    do_reset();
    job_num = 1; start = 1; in_vld = 1; out_rdy = 1;
    cyc(); start = 0;
    nw = 0; nr = 0; nd = 0; done_t = -1; first_rd = -1; first_vld = -1;
    for (int i = 1; i <= 60 && nd == 0; i++) begin
      cyc();
      if (buf_wen) begin
        chk("s1_waddr", buf_waddr, nw); chk("s1_wsel", buf_wsel, 0);
        nw++;
        if (nw == 8) chk("s1_full_after8", buf_full, 2'b01);
      end
      if (buf_rd) begin
        chk("s1_raddr", buf_raddr, nr); chk("s1_rsel", buf_rsel, 0);
        if (nr == 0) first_rd = i;
        nr++;
      end
      if (out_vld && first_vld < 0) first_vld = i;
      if (done) begin nd++; done_t = i; end
    end
    chk("s1_writes", nw, 8); chk("s1_reads", nr, 8); chk("s1_done", nd, 1);
    chk("s1_vld_lag", first_vld - first_rd, 1);
    chk("s1_done_time", done_t, 18);
    chk("s1_busy_low", busy, 0);
    cyc();
    chk("s1_done_once", done, 0);

    // ---- back-pressure ----
    do_reset();
    job_num = 3; start = 1; in_vld = 1; out_rdy = 0;
    cyc(); start = 0;
    nw = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (buf_wen) nw++; end
    chk("bp_writes", nw, 16); chk("bp_full", buf_full, 2'b11); chk("bp_in_rdy", in_rdy, 0);
    out_rdy = 1; nr = 0; nd = 0;
    for (int i = 0; i < 120 && nd == 0; i++) begin
      cyc();
      if (buf_rd) begin
        nr++;
        if (nr <= 8) chk("bp_rsel0", buf_rsel, 0);
      end
      if (buf_wen) begin
        nw++;
        if (nw == 17) begin chk("bp_w17_sel", buf_wsel, 0); chk("bp_w17_after_free", nr >= 8, 1); end
      end
      if (done) nd++;
    end
    chk("bp_reads", nr, 24); chk("bp_writes_total", nw, 24); chk("bp_done", nd, 1);

    // ---- overlap ----
    do_reset();
    job_num = 4; start = 1; in_vld = 1; out_rdy = 1;
    cyc(); start = 0;
    ovl = 0; done_t = -1;
    for (int i = 1; i <= 80 && done_t < 0; i++) begin
      cyc();
      if (buf_wen && buf_wsel && buf_rd && !buf_rsel) ovl = 1;
      if (done) done_t = i;
    end
    chk("ovl_seen", ovl, 1);
    chk("ovl_cycles_bound", (done_t > 0) && (done_t <= 44), 1);
    chk("ovl_cycles", done_t, 42);

    // ---- zero job ----
    do_reset();
    job_num = 0; start = 1; in_vld = 1; out_rdy = 1;
    cyc(); start = 0;
    chk("z_done_c1", done, 0); chk("z_busy_c1", busy, 1);
    cyc();
    chk("z_done_c2", done, 1); chk("z_wen", buf_wen, 0); chk("z_rd", buf_rd, 0);
    cyc();
    chk("z_done_c3", done, 0);

    // ---- abort mid-frame ----
    do_reset();
    job_num = 1; start = 1; in_vld = 1; out_rdy = 0;
    cyc(); start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); if (buf_wen && buf_waddr == 3'd4) seen = 1; end
    chk("ab_reached_wcnt5", seen, 1);
    abort = 1;
    cyc(); abort = 0;
    chk("ab_busy", busy, 0); chk("ab_full", buf_full, 0); chk("ab_in_rdy", in_rdy, 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin cyc(); if (done) nd++; end
    chk("ab_no_done", nd, 0);
    job_num = 1; start = 1; out_rdy = 1;
    cyc(); start = 0;
    nw = 0; nd = 0;
    for (int i = 0; i < 60 && nd == 0; i++) begin
      cyc();
      if (buf_wen) begin
        if (nw == 0) begin chk("ab_re_waddr0", buf_waddr, 0); chk("ab_re_wsel0", buf_wsel, 0); end
        nw++;
      end
      if (done) nd++;
    end
    chk("ab_re_writes", nw, 8); chk("ab_re_done", nd, 1);

    // ---- async reset mid-read ----
    do_reset();
    job_num = 2; start = 1; in_vld = 1; out_rdy = 1;
    cyc(); start = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin cyc(); if (buf_rd) seen = 1; end
    chk("ar_seen_rd", seen, 1);
    #3;
    rst = 1;
    model_reset();
    #1;
    chk("ar_busy", busy, 0);       chk("ar_done", done, 0);
    chk("ar_wen", buf_wen, 0);     chk("ar_rd", buf_rd, 0);
    chk("ar_vld", out_vld, 0);     chk("ar_full", buf_full, 0);
    chk("ar_waddr", buf_waddr, 0); chk("ar_raddr", buf_raddr, 0);
    chk("ar_wsel", buf_wsel, 0);   chk("ar_rsel", buf_rsel, 0);
    in_vld = 0; out_rdy = 0;
    cyc();
    rst = 0;

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      in_vld  = ($urandom % 4) != 0;
      out_rdy = ($urandom % 3) != 0;
      start   = ($urandom % 12) == 0;
      job_num = 8'($urandom % 5);
      abort   = ($urandom % 250) == 0;
      cyc();
    end
    start = 0; abort = 0; in_vld = 1; out_rdy = 1;
    for (int i = 0; i < 300 && m_phase != 0; i++) cyc();
    chk("rand_idle", busy, 0);

    // ---- RD_LATENCY=3 single job ----
    do_reset();
    t_job = 1; t_start = 1; t_vld = 1; t_rdy = 1;
    cyc(); t_start = 0;
    nr = 0; nv = 0; done_t = -1; first_rd = -1; last_rd = -1; first_vld = -1; last_vld = -1;
    for (int i = 1; i <= 60 && done_t < 0; i++) begin
      cyc();
      if (t_rd) begin if (first_rd < 0) first_rd = i; last_rd = i; nr++; end
      if (t_out_vld) begin if (first_vld < 0) first_vld = i; last_vld = i; nv++; end
      if (t_done) done_t = i;
    end
    chk("l3_reads", nr, 8); chk("l3_vlds", nv, 8);
    chk("l3_vld_lag", first_vld - first_rd, 3);
    chk("l3_done_after_vld", done_t - last_vld, 1);
    chk("l3_drain", done_t - last_rd, 4);
    chk("l3_done_time", done_t, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
